// File: rtl/sub1_stream.sv
// rtl/sub1_stream.sv - streaming x-1 decrement with borrow, buffered in an output FIFO (option: SUB1_STREAM_SATURATE_EN)
module sub1_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_borrow,
  output logic [15:0]      count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             run;
  logic             push;
  logic             pop;
  logic             in_borrow;
  logic [WIDTH-1:0] in_result;
  logic [WIDTH:0]   head;

  // run holds in_ready low in the cycle following any reset edge
  assign in_ready  = run && (occ < FULL_OCC);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd_ptr];
  assign out_data   = out_valid ? head[WIDTH-1:0] : '0;
  assign out_borrow = out_valid ? head[WIDTH] : 1'b0;

  // Decrement the incoming operand; zero either wraps to all ones or clamps at zero
  always_comb begin
    in_borrow = (in_data == '0);
`ifdef SUB1_STREAM_SATURATE_EN
    in_result = in_borrow ? '0 : in_data - 1'b1;
`else
    in_result = in_data - 1'b1;
`endif
  end

  // FIFO storage: entries are not reset, out_valid gates their visibility
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {in_borrow, in_result};
    end
  end

  // Pointers, occupancy, delivered-result counter and post-reset ready gate
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      count  <= '0;
      run    <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub1_stream.sv
// tb/tb_sub1_stream.sv - directed table-driven bench for sub1_stream
module tb_sub1_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_borrow;
  logic [15:0] count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] got[$];
  int got_cyc[$];
  int exp_count;

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic       borrow;
  } vec_t;
  vec_t vecs[7];

  sub1_stream #(.WIDTH(8), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_borrow(out_borrow), .count(count)
  );

  always #5 clk = ~clk;

  // Record every delivered result and the cycle it was taken in
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && out_valid && out_ready) begin
      got.push_back(out_data);
      got_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dec(input int x);
    logic [7:0] v;
    v = x[7:0];
`ifdef SUB1_STREAM_SATURATE_EN
    if (v == 8'd0) return 8'd0;
`endif
    return v - 8'd1;
  endfunction

  initial begin
    vecs[0] = '{8'd1,   8'd0,   1'b0};
    vecs[1] = '{8'd2,   8'd1,   1'b0};
    vecs[2] = '{8'd128, 8'd127, 1'b0};
    vecs[3] = '{8'd255, 8'd254, 1'b0};
`ifdef SUB1_STREAM_SATURATE_EN
    vecs[4] = '{8'd0,   8'd0,   1'b1};
`else
    vecs[4] = '{8'd0,   8'd255, 1'b1};
`endif
    vecs[5] = '{8'd5,   8'd4,   1'b0};
    vecs[6] = '{8'hA5,  8'hA4,  1'b0};

    // reset held two cycles
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_borrow", out_borrow, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", in_ready, 1);

    // first push of 5, one-cycle latency
    in_valid = 1'b1; in_data = 8'd5;
    tick();
    in_valid = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 8'd4);
    chk("first_borrow", out_borrow, 0);
    out_ready = 1'b1;
    tick();
    chk("first_count", count, 1);
    chk("first_drained", out_valid, 0);
    exp_count = 1;

    // boundary operands streamed with out_ready high
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = vecs[i].din;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].dout);
      chk($sformatf("vec%0d_borrow", i), out_borrow, vecs[i].borrow);
    end
    in_valid = 1'b0;
    tick();
    exp_count += 7;
    chk("vec_count", count, exp_count);

    // backpressure, then full FIFO with a simultaneous pop
    got.delete(); got_cyc.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd10; tick();
    in_data = 8'd20; tick();
    chk("bp_full_ready", in_ready, 0);
    in_data = 8'd30; tick();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_head", out_data, 8'd9);
    out_ready = 1'b1;
    chk("full_pop_ready", in_ready, 0);
    tick();
    chk("after_pop_ready", in_ready, 1);
    chk("after_pop_head", out_data, 8'd19);
    tick();
    in_valid = 1'b0;
    chk("bp_head3", out_data, 8'd29);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_n", got.size(), 3);
    if (got.size() == 3) begin
      chk("bp_o0", got[0], 8'd9);
      chk("bp_o1", got[1], 8'd19);
      chk("bp_o2", got[2], 8'd29);
    end
    exp_count += 3;
    chk("bp_count", count, exp_count);

    // continuous streaming of 300 operands
    got.delete(); got_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = i[7:0];
      if (!in_ready) begin
        total++; bad++;
        $display("FAIL stream_ready at %0d: got 0 expected 1", i);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("stream_n", got.size(), 300);
    if (got.size() == 300) begin
      for (int i = 0; i < 300; i++) begin
        chk($sformatf("stream_d%0d", i), got[i], dec(i));
        chk($sformatf("stream_c%0d", i), got_cyc[i], got_cyc[0] + i);
      end
    end
    exp_count += 300;
    chk("stream_count", count, exp_count);

    // reset with two entries buffered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'd1; tick();
    in_data = 8'd2; tick();
    in_valid = 1'b0;
    chk("mid_buffered", out_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_valid", out_valid, 0);
    chk("mid_count", count, 0);
    chk("mid_ready", in_ready, 0);
    tick();
    got.delete(); got_cyc.delete();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'd7; tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("mid_n", got.size(), 1);
    if (got.size() == 1) chk("mid_d", got[0], 8'd6);
    chk("mid_count2", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
